// File: rtl/pkt_af_pkg.sv
// Shared types and widths for the almost_full packet sender.
package pkt_af_pkg;

    localparam int unsigned CNT_W            = 32;
    localparam int unsigned SYMBOLS_PER_BEAT = 64;
    localparam int unsigned BITS_PER_SYMBOL  = 8;
    localparam int unsigned DATA_W           = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL;
    localparam int unsigned EMPTY_W          = $clog2(SYMBOLS_PER_BEAT);

    typedef enum logic [0:0] {IDLE, IN_PKT} pkt_state_t;

    // One beat as written into the downstream FIFO (default FIFO widths).
    typedef struct packed {
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic [DATA_W-1:0]  data;
    } pkt_beat_t;

endpackage

// File: rtl/pkt_stat_counter.sv
// Statistics counter: increments on inc, either wrapping or saturating at all-ones.
module pkt_stat_counter
    import pkt_af_pkg::*;
#(
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count register; a saturating counter parks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            if (!(SATURATE && (&count))) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pkt_af_sender.sv
// Avalon-ST to almost_full-only packet FIFO front end with framing repair and statistics.
// Optional macro PKT_AF_SENDER_BOUNDARY_THROTTLE_EN: throttle only between packets.
module pkt_af_sender
    import pkt_af_pkg::*;
#(
    parameter int unsigned SYMBOLS_PER_BEAT = 64,
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    parameter int unsigned MAX_PKT_BEATS    = 32
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0] in_data,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic                                        in_startofpacket,
    input  logic                                        in_endofpacket,
    input  logic [$clog2(SYMBOLS_PER_BEAT)-1:0]         in_empty,
    output logic [SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0] out_data,
    output logic                                        out_valid,
    output logic                                        out_startofpacket,
    output logic                                        out_endofpacket,
    output logic [$clog2(SYMBOLS_PER_BEAT)-1:0]         out_empty,
    input  logic                                        almost_full,
    output logic [CNT_W-1:0]                            pkt_count,
    output logic [CNT_W-1:0]                            beat_count,
    output logic [CNT_W-1:0]                            err_count,
    output logic [CNT_W-1:0]                            stall_count
);

    localparam int unsigned EW = $clog2(SYMBOLS_PER_BEAT);

    if (MAX_PKT_BEATS < 1) begin : g_bad_max_pkt
        $error("MAX_PKT_BEATS must be at least 1");
    end

    logic       af_q;
    pkt_state_t state_q;
    pkt_state_t state_nxt;
    logic       accept_c;
    logic       fwd_c;
    logic       pkt_inc_c;
    logic       err_inc_c;
    logic       stall_inc_c;

`ifdef PKT_AF_SENDER_BOUNDARY_THROTTLE_EN
    // Almost_full only blocks the start of a packet; an open packet streams to EOP.
    assign in_ready = !(af_q && (state_q == IDLE));
`else
    // Beat-level throttle straight from the registered almost_full.
    assign in_ready = !af_q;
`endif

    assign accept_c    = in_valid && in_ready;
    assign stall_inc_c = in_valid && !in_ready;

    // Register almost_full once; held high through reset so nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            af_q <= 1'b1;
        end else begin
            af_q <= almost_full;
        end
    end

    // Framing state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next framing state; only accepted beats move the FSM.
    always_comb begin
        state_nxt = state_q;
        if (accept_c) begin
            case (state_q)
                IDLE: begin
                    if (in_startofpacket && !in_endofpacket) begin
                        state_nxt = IN_PKT;
                    end
                end
                IN_PKT: begin
                    if (in_endofpacket) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Forward/drop decision and statistic strobes for the accepted beat.
    always_comb begin
        fwd_c     = 1'b0;
        pkt_inc_c = 1'b0;
        err_inc_c = 1'b0;
        if (accept_c) begin
            case (state_q)
                IDLE: begin
                    if (in_startofpacket) begin
                        fwd_c     = 1'b1;
                        pkt_inc_c = in_endofpacket;
                    end else begin
                        err_inc_c = 1'b1;
                    end
                end
                IN_PKT: begin
                    fwd_c     = 1'b1;
                    pkt_inc_c = in_endofpacket;
                    err_inc_c = in_startofpacket;
                end
                default: begin
                    err_inc_c = 1'b1;
                end
            endcase
        end
    end

    // Output beat register; payload holds when nothing is forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_empty         <= '0;
            out_data          <= '0;
        end else begin
            out_valid <= fwd_c;
            if (fwd_c) begin
                out_startofpacket <= in_startofpacket;
                out_endofpacket   <= in_endofpacket;
                out_empty         <= in_endofpacket ? in_empty : EW'(0);
                out_data          <= in_data;
            end
        end
    end

`ifdef PKT_AF_SENDER_BOUNDARY_THROTTLE_EN
    logic [CNT_W-1:0] pkt_len_q;

    // Beats of the current packet, used to catch packets that exceed the headroom.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_len_q <= '0;
        end else if (fwd_c) begin
            pkt_len_q <= in_startofpacket ? CNT_W'(1) : pkt_len_q + CNT_W'(1);
        end
    end

    // Flag a packet growing past MAX_PKT_BEATS.
    always_ff @(posedge clk) begin
        if (!rst && fwd_c && !in_startofpacket) begin
            assert (pkt_len_q < CNT_W'(MAX_PKT_BEATS));
        end
    end
`endif

    pkt_stat_counter #(.SATURATE(1'b0)) u_pkt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pkt_inc_c),
        .count (pkt_count)
    );

    pkt_stat_counter #(.SATURATE(1'b0)) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fwd_c),
        .count (beat_count)
    );

    pkt_stat_counter #(.SATURATE(1'b1)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc_c),
        .count (err_count)
    );

    pkt_stat_counter #(.SATURATE(1'b0)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc_c),
        .count (stall_count)
    );

endmodule
